z80_bus_sched: RTL
==================

// Module: z80_bus_sched
// PURPOSE
//  Sequences the TV80 CPU and shares its memory port with one DMA requester (tape/snapshot loader).
//  - Generates the CPU clock enables cen_p/cen_n.
//  - Turns CPU mreq/rd/wr into single-strobe requests on a shared memory port.
//  - Stretches CPU cycles with wait_n until the memory acknowledges.
//  - Takes the bus for DMA through the busrq_n/busak_n handshake.
//  Sits between the CPU wrapper and the system RAM/ROM arbiter.
// PARAMETERS
//  DIV    4  clk cycles per CPU T-state; even, >=2
//  AW     16 address width
// PORTS
//  clk          in  1   system clock
//  reset_n      in  1   synchronous, active-low reset
//  pause        in  1   1 = freeze CPU (no enables generated)
//  cen_p        out 1   CPU positive-phase enable, 1-clk pulse
//  cen_n        out 1   CPU negative-phase enable, 1-clk pulse
//  cpu_mreq_n   in  1   CPU memory request
//  cpu_rd_n     in  1   CPU read strobe
//  cpu_wr_n     in  1   CPU write strobe
//  cpu_rfsh_n   in  1   CPU refresh
//  cpu_a        in  AW  CPU address
//  cpu_dout     in  8   CPU write data
//  cpu_di       out 8   read data latched for CPU
//  cpu_wait_n   out 1   CPU wait
//  cpu_busrq_n  out 1   bus request to CPU
//  cpu_busak_n  in  1   bus acknowledge from CPU
//  dma_req      in  1   level: DMA wants the bus
//  dma_gnt      out 1   DMA owns memory port
//  dma_stb      in  1   1-clk access strobe, valid only while dma_gnt=1
//  dma_we       in  1   DMA write
//  dma_addr     in  AW  DMA address
//  dma_wdata    in  8   DMA write data
//  dma_ack      out 1   DMA access complete, 1 clk
//  mem_req      out 1   1-clk request strobe to memory
//  mem_we       out 1   write qualifier, valid with mem_req
//  mem_addr     out AW  address, held from mem_req to mem_ack
//  mem_wdata    out 8   write data, held from mem_req to mem_ack
//  mem_rdata    in  8   read data, valid with mem_ack
//  mem_ack      in  1   1-clk completion, >=1 clk after mem_req
// BEHAVIOUR
//  Reset values
//   - Phase counter 0.
//   - cen_p = 0, cen_n = 0.
//   - cpu_wait_n = 1, cpu_busrq_n = 1.
//   - dma_gnt = 0, dma_ack = 0, mem_req = 0, mem_we = 0.
//   - mem_addr = 0, mem_wdata = 0, cpu_di = 8'hFF.
//   - FSM state = CPU; busy = 0, done = 0.
//  Clock enables
//   - Phase counter counts 0..DIV-1 and wraps.
//   - cen_p is asserted at phase 0; cen_n is asserted at phase DIV/2.
//   - pause=1 holds the counter and forces both enables to 0; counting resumes at the held phase.
//  CPU access (FSM state CPU)
//   - Start: mreq_n=0, rfsh_n=1, (rd_n=0 or wr_n=0), busy=0, done=0.
//   - On start, in the same clk:
//     - mem_req=1 for 1 clk; mem_we=~wr_n.
//     - mem_addr/mem_wdata take cpu_a/cpu_dout.
//     - busy is set.
//   - While busy, cpu_wait_n=0. Registered: it drops the clk after the start.
//   - On mem_ack while busy:
//     - Reads latch mem_rdata into cpu_di.
//     - busy clears, done sets, cpu_wait_n returns to 1 the next clk.
//   - done clears when mreq_n=1, so each CPU cycle produces exactly one request.
//   - Refresh cycles (rfsh_n=0) never issue a request.
//  DMA FSM
//   - CPU -> REQ: when dma_req=1 and busy=0. cpu_busrq_n=0.
//   - REQ -> GNT: when cpu_busak_n=0. dma_gnt=1.
//   - GNT:
//     - dma_stb issues mem_req with the dma_* fields.
//     - mem_ack produces dma_ack=1 for 1 clk.
//     - A dma_stb arriving while a DMA access is outstanding is dropped.
//   - GNT -> REL: when dma_req=0 and no DMA access is outstanding. dma_gnt=0, cpu_busrq_n=1.
//   - REL -> CPU: when cpu_busak_n=1.
//   - If dma_req drops while in REQ, the FSM goes to REL.
//  Simultaneous events
//   - A CPU start and dma_req in the same clk: the CPU wins. REQ is entered after its ack.
//   - A mem_ack with nothing outstanding is ignored.
//  Reset mid-access: all state returns to reset values; a late mem_ack is ignored per the rule above.
// STRUCTURE
//  - Package zx_bus_pkg holds the FSM state enum (CPU, REQ, GNT, REL) and DIV legality check constants.
//  - Sub-module z80_cen_gen holds the phase counter and cen_p/cen_n/pause logic.
// TESTING
//  1. DIV=4, pause=0: cen_p at phases 0,4,8..; cen_n at 2,6,10... Pause 3 clks: no enables, phase held.
//  2. CPU read A=16'h4000, mem_ack 5 clks after mem_req, rdata=8'h3C:
//     one mem_req with we=0; wait_n low until ack; cpu_di=8'h3C.
//  3. CPU write A=16'h4001, dout=8'hA5: one mem_req with we=1, addr=16'h4001, wdata=8'hA5; none during refresh.
//  4. dma_req during a busy CPU access: busrq_n falls only after the ack.
//     Then busak_n=0 -> dma_gnt=1; 3 dma_stb writes -> 3 dma_ack.
//     Then dma_req=0 -> busrq_n=1; busak_n=1 -> state CPU.
//  5. reset_n=0 while busy: next clk all outputs at reset values; a following stray mem_ack produces no dma_ack and no cpu_di update.

Source files
------------

// File: rtl/z80_bus_sched_pkg.sv
// zx_bus_pkg: shared types and constants for the Z80 bus scheduler.
//   sched_state_e - bus ownership FSM states (CPU, REQ, GNT, REL)
//   DIV_MIN/DIV_STEP, div_legal() - legality check for the clock divider
package zx_bus_pkg;

    typedef enum logic [1:0] {
        ST_CPU = 2'd0,  // CPU owns the memory port
        ST_REQ = 2'd1,  // busrq_n asserted, waiting for busak_n
        ST_GNT = 2'd2,  // DMA owns the memory port
        ST_REL = 2'd3   // busrq_n released, waiting for CPU to take the bus back
    } sched_state_e;

    localparam int DIV_MIN  = 2;
    localparam int DIV_STEP = 2;

    function automatic bit div_legal(input int div);
        return (div >= DIV_MIN) && ((div % DIV_STEP) == 0);
    endfunction

endpackage

// File: rtl/z80_bus_sched_if.sv
// z80_bus_sched_if: single-strobe memory port shared by CPU and DMA.
//   mem_req   - 1-clk request strobe
//   mem_we    - write qualifier, valid with mem_req
//   mem_addr  - address, held from mem_req to mem_ack
//   mem_wdata - write data, held from mem_req to mem_ack
//   mem_rdata - read data, valid with mem_ack
//   mem_ack   - 1-clk completion
// master: the scheduler; slave: the RAM/ROM arbiter.
interface z80_bus_sched_if #(
    parameter int AW = 16
);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    logic          mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/z80_bus_sched_cen_gen.sv
// z80_cen_gen: CPU clock-enable generator.
//   clk, reset_n - system clock, synchronous active-low reset
//   pause        - 1 holds the phase counter and suppresses both enables
//   cen_p        - 1-clk pulse in the clk where the phase is 0
//   cen_n        - 1-clk pulse in the clk where the phase is DIV/2
// Enables are registered and aligned with the phase they announce, so a
// pulse only occurs when the counter actually stepped into that phase.
module z80_cen_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pause,
    output logic cen_p,
    output logic cen_n
);
    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [PW-1:0] phase_q, phase_d;
    logic          cen_p_q, cen_p_d;
    logic          cen_n_q, cen_n_d;

    always_comb begin
        phase_d = phase_q;
        cen_p_d = 1'b0;
        cen_n_d = 1'b0;
        if (!pause) begin
            phase_d = (phase_q == PW'(DIV - 1)) ? '0 : phase_q + PW'(1);
            cen_p_d = (phase_d == '0);
            cen_n_d = (phase_d == PW'(DIV / 2));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase_q <= '0;
            cen_p_q <= 1'b0;
            cen_n_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cen_p_q <= cen_p_d;
            cen_n_q <= cen_n_d;
        end
    end

    assign cen_p = cen_p_q;
    assign cen_n = cen_n_q;
endmodule

// File: rtl/z80_bus_sched.sv
// z80_bus_sched: sequences the TV80 and shares its memory port with a DMA loader.
//   clk, reset_n, pause        - clock, sync active-low reset, CPU freeze
//   cen_p, cen_n               - CPU clock enables
//   cpu_*                      - CPU bus: strobes/address/data in, read data and
//                                wait out, busrq_n out / busak_n in
//   dma_req/gnt/stb/we/addr/wdata/ack - DMA requester handshake
//   mem                        - shared memory port (master side)
// Exactly one access (CPU or DMA) is outstanding at a time: CPU accesses only
// start in ST_CPU and DMA accesses only in ST_GNT.
module z80_bus_sched
    import zx_bus_pkg::*;
#(
    parameter int DIV = 4,
    parameter int AW  = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          pause,
    output logic          cen_p,
    output logic          cen_n,
    input  logic          cpu_mreq_n,
    input  logic          cpu_rd_n,
    input  logic          cpu_wr_n,
    input  logic          cpu_rfsh_n,
    input  logic [AW-1:0] cpu_a,
    input  logic [7:0]    cpu_dout,
    output logic [7:0]    cpu_di,
    output logic          cpu_wait_n,
    output logic          cpu_busrq_n,
    input  logic          cpu_busak_n,
    input  logic          dma_req,
    output logic          dma_gnt,
    input  logic          dma_stb,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [7:0]    dma_wdata,
    output logic          dma_ack,
    z80_bus_sched_if.master mem
);
    if (!div_legal(DIV)) begin : g_div_chk
        $error("z80_bus_sched: DIV must be even and >= 2");
    end

    z80_cen_gen #(.DIV(DIV)) u_cen (
        .clk     (clk),
        .reset_n (reset_n),
        .pause   (pause),
        .cen_p   (cen_p),
        .cen_n   (cen_n)
    );

    sched_state_e  state_q, state_d;
    logic          busy_q, busy_d;        // CPU access outstanding
    logic          done_q, done_d;        // CPU cycle served, waiting for mreq_n=1
    logic          dma_out_q, dma_out_d;  // DMA access outstanding
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]    mem_wdata_q, mem_wdata_d;
    logic [7:0]    cpu_di_q, cpu_di_d;
    logic          cpu_wait_n_q, cpu_wait_n_d;
    logic          dma_ack_q, dma_ack_d;

    logic cpu_start, dma_issue, ack_cpu, ack_dma;

    assign cpu_start = (state_q == ST_CPU) && !cpu_mreq_n && cpu_rfsh_n &&
                       (!cpu_rd_n || !cpu_wr_n) && !busy_q && !done_q;
    assign dma_issue = (state_q == ST_GNT) && dma_stb && !dma_out_q;
    // Acks with nothing outstanding fall through both of these.
    assign ack_cpu   = mem.mem_ack && busy_q;
    assign ack_dma   = mem.mem_ack && dma_out_q;

    // Datapath / handshake next state
    always_comb begin
        busy_d      = busy_q;
        done_d      = done_q;
        dma_out_d   = dma_out_q;
        mem_req_d   = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_di_d    = cpu_di_q;
        dma_ack_d   = 1'b0;

        if (cpu_start) begin
            mem_req_d   = 1'b1;
            mem_we_d    = !cpu_wr_n;
            mem_addr_d  = cpu_a;
            mem_wdata_d = cpu_dout;
            busy_d      = 1'b1;
        end else if (dma_issue) begin
            mem_req_d   = 1'b1;
            mem_we_d    = dma_we;
            mem_addr_d  = dma_addr;
            mem_wdata_d = dma_wdata;
            dma_out_d   = 1'b1;
        end

        if (ack_cpu) begin
            if (!mem_we_q) cpu_di_d = mem.mem_rdata;
            busy_d = 1'b0;
            done_d = 1'b1;
        end else if (cpu_mreq_n) begin
            done_d = 1'b0;
        end

        if (ack_dma) begin
            dma_ack_d = 1'b1;
            dma_out_d = 1'b0;
        end

        cpu_wait_n_d = !busy_d;
    end

    // Ownership FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            // A same-clk CPU start wins; REQ follows once its ack is in.
            ST_CPU: if (dma_req && !busy_q && !cpu_start) state_d = ST_REQ;
            ST_REQ: begin
                if (!dma_req)          state_d = ST_REL;
                else if (!cpu_busak_n) state_d = ST_GNT;
            end
            ST_GNT: if (!dma_req && !dma_out_q && !dma_issue) state_d = ST_REL;
            ST_REL: if (cpu_busak_n) state_d = ST_CPU;
            default: state_d = ST_CPU;
        endcase
    end

    // Ownership FSM: outputs
    always_comb begin
        cpu_busrq_n = !((state_q == ST_REQ) || (state_q == ST_GNT));
        dma_gnt     = (state_q == ST_GNT);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_CPU;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            dma_out_q    <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_di_q     <= 8'hFF;
            cpu_wait_n_q <= 1'b1;
            dma_ack_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            dma_out_q    <= dma_out_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_di_q     <= cpu_di_d;
            cpu_wait_n_q <= cpu_wait_n_d;
            dma_ack_q    <= dma_ack_d;
        end
    end

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign cpu_di        = cpu_di_q;
    assign cpu_wait_n    = cpu_wait_n_q;
    assign dma_ack       = dma_ack_q;
endmodule
